// File: rtl/aes_mode_ctrl.sv
// Mode controller around an iterative AES encrypt core (ECB, CBC-encrypt, CTR).
// One block in flight. Results queue in a small output FIFO that drains independently of the FSM.

// Output queue: pop_dat is the head, visible while !empty; push on a full queue is dropped unless a pop happens on the same edge.
// Entry is visible the cycle after push; simultaneous push/pop keeps the count.
module aes_mode_fifo #(
  parameter int W   = 8,
  parameter int DEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       empty,
  output logic [$clog2(DEP+1)-1:0]   cnt
);
  localparam int AW = (DEP > 1) ? $clog2(DEP) : 1;
  localparam int CW = $clog2(DEP + 1);

  logic [W-1:0]  mem [DEP];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((cnt != CW'(DEP)) | do_pop);
  assign pop_dat = mem[rd_ptr];

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEP - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEP; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Sequences the core one block at a time: accept -> ld pulse -> wait done -> push result.
// in_ready only in READY with FIFO room, so a full FIFO stalls input, never the core.
module aes_mode_ctrl #(
  parameter int BLK_W    = 128,
  parameter int KEY_W    = 256,
  parameter int CTR_W    = 32,
  parameter int FIFO_DEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kld,
  input  logic [1:0]       cfg_mode,
  input  logic [KEY_W-1:0] key,
  input  logic [BLK_W-1:0] iv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_last,
  output logic             core_ld,
  output logic [KEY_W-1:0] core_key,
  output logic [BLK_W-1:0] core_text_in,
  input  logic [BLK_W-1:0] core_text_out,
  input  logic             core_done,
  output logic             busy,
  output logic             err
);
  localparam int CW = $clog2(FIFO_DEP + 1);
  localparam logic [1:0] M_ECB = 2'b00;
  localparam logic [1:0] M_CBC = 2'b01;
  localparam logic [1:0] M_CTR = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_READY, S_ISSUE, S_WAIT, S_PUSH} state_t;

  state_t         state;
  logic [1:0]     mode;
  logic [BLK_W-1:0] chain;
  logic [BLK_W-1:0] hold_dat;
  logic             hold_last;
  logic [BLK_W-1:0] res;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_empty;
  logic             accept;
  logic [BLK_W:0]   fifo_head;

  assign in_ready  = (state == S_READY) && (fifo_cnt < CW'(FIFO_DEP));
  assign accept    = in_valid & in_ready;
  assign busy      = (state != S_IDLE);
  assign out_valid = ~fifo_empty;
  assign out_last  = fifo_head[BLK_W];
  assign out_data  = fifo_head[BLK_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mode         <= M_ECB;
      chain        <= '0;
      core_key     <= '0;
      core_text_in <= '0;
      core_ld      <= 1'b0;
      hold_dat     <= '0;
      hold_last    <= 1'b0;
      res          <= '0;
      err          <= 1'b0;
    end else begin
      core_ld <= 1'b0;
      case (state)
        S_IDLE, S_READY: begin
          if (accept) begin
            // The handshake wins; a kld landing on the accept edge is treated as mid-block.
            hold_dat  <= in_data;
            hold_last <= in_last;
            core_ld   <= 1'b1;
            state     <= S_ISSUE;
            if (kld) err <= 1'b1;
            case (mode)
              M_CBC:   core_text_in <= in_data ^ chain;
              M_CTR:   core_text_in <= chain;
              default: core_text_in <= in_data;
            endcase
          end else if (kld) begin
            if (cfg_mode == M_RSV) begin
              err <= 1'b1;
            end else begin
              mode     <= cfg_mode;
              core_key <= key;
              chain    <= iv;
              state    <= S_READY;
            end
          end
        end
        S_ISSUE: begin
          if (kld) err <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (kld) err <= 1'b1;
          if (core_done) begin
            state <= S_PUSH;
            case (mode)
              M_CBC: begin
                res   <= core_text_out;
                chain <= core_text_out;
              end
              M_CTR: begin
                res                <= core_text_out ^ hold_dat;
                chain[CTR_W-1:0]   <= chain[CTR_W-1:0] + 1'b1;
              end
              default: res <= core_text_out;
            endcase
          end
        end
        S_PUSH: begin
          if (kld) err <= 1'b1;
          state <= hold_last ? S_IDLE : S_READY;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  aes_mode_fifo #(.W(BLK_W + 1), .DEP(FIFO_DEP)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (state == S_PUSH),
    .push_dat ({hold_last, res}),
    .pop      (out_ready),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty),
    .cnt      (fifo_cnt)
  );
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with a stub core: text_out = text_in ^ key[127:0], done 12 cycles after ld.
module tb_aes_mode_ctrl;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         kld = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic [255:0] key = '0;
  logic [127:0] iv = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic         core_ld;
  logic [255:0] core_key;
  logic [127:0] core_text_in;
  logic [127:0] core_text_out = '0;
  logic         core_done = 1'b0;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;
  int stub_cnt = 0;

  always #5 clk = ~clk;

  aes_mode_ctrl dut (
    .clk(clk), .rst(rst), .kld(kld), .cfg_mode(cfg_mode), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_text_out(core_text_out), .core_done(core_done), .busy(busy), .err(err)
  );

  // Stub core; deliberately not reset so a dropped block still produces a late done.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_ld) begin
      stub_cnt      <= 12;
      core_text_out <= core_text_in ^ core_key[127:0];
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) core_done <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_kld(input logic [1:0] m, input logic [255:0] k, input logic [127:0] v);
    cfg_mode = m; key = k; iv = v; kld = 1'b1;
    @(negedge clk);
    kld = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic l, input int bound, output bit ok);
    in_valid = 1'b1; in_data = d; in_last = l; ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [127:0] ed, input logic el);
    bit seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk({tag, " valid"}, 256'(seen), 256'(1));
    if (seen) begin
      chk({tag, " data"}, 256'(out_data), 256'(ed));
      chk({tag, " last"}, 256'(out_last), 256'(el));
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    bit seen;
    int acc;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst busy", 256'(busy), 256'(0));
    chk("rst in_ready", 256'(in_ready), 256'(0));
    chk("rst out_valid", 256'(out_valid), 256'(0));
    chk("rst out_data", 256'(out_data), 256'(0));
    chk("rst err", 256'(err), 256'(0));
    chk("rst core_ld", 256'(core_ld), 256'(0));
    chk("rst core_key", core_key, 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // ECB single block with latency checks
    do_kld(2'b00, 256'd107, 128'd0);
    chk("ecb busy", 256'(busy), 256'(1));
    chk("ecb core_key", core_key, 256'd107);
    chk("ecb in_ready", 256'(in_ready), 256'(1));
    send(128'd100, 1'b1, 20, ok);
    chk("ecb accept", 256'(ok), 256'(1));
    chk("ecb core_ld T+1", 256'(core_ld), 256'(1));
    chk("ecb core_text_in", 256'(core_text_in), 256'h64);
    @(negedge clk);
    chk("ecb core_ld pulse", 256'(core_ld), 256'(0));
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (core_done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("ecb done seen", 256'(seen), 256'(1));
    chk("ecb out_valid at done", 256'(out_valid), 256'(0));
    @(negedge clk);
    chk("ecb out_valid done+1", 256'(out_valid), 256'(0));
    @(negedge clk);
    chk("ecb out_valid done+2", 256'(out_valid), 256'(1));
    chk("ecb busy end", 256'(busy), 256'(0));
    recv("ecb out", 128'h0F, 1'b1);
    chk("ecb drained", 256'(out_valid), 256'(0));

    // CBC two blocks
    do_kld(2'b01, 256'd107, 128'd1);
    send(128'h64, 1'b0, 20, ok);
    chk("cbc b0 text_in", 256'(core_text_in), 256'h65);
    recv("cbc b0", 128'h0E, 1'b0);
    send(128'h64, 1'b1, 20, ok);
    chk("cbc b1 text_in", 256'(core_text_in), 256'h6A);
    recv("cbc b1", 128'h01, 1'b1);
    chk("cbc idle", 256'(busy), 256'(0));

    // CTR with counter wrap; upper bits must not take the carry
    do_kld(2'b10, 256'd0, {96'h1234, 32'hFFFF_FFFF});
    send(128'd0, 1'b0, 20, ok);
    recv("ctr b0", {96'h1234, 32'hFFFF_FFFF}, 1'b0);
    send(128'd0, 1'b0, 20, ok);
    recv("ctr b1 wrap", {96'h1234, 32'h0}, 1'b0);
    send(128'hFF, 1'b1, 20, ok);
    recv("ctr b2 xor", {96'h1234, 32'hFE}, 1'b1);

    // Backpressure: FIFO of 4 fills, remaining blocks refused
    do_kld(2'b00, 256'd0, 128'd0);
    out_ready = 1'b0;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      send(128'(i), 1'b0, 30, ok);
      if (ok) acc++;
    end
    chk("bp accepted", 256'(acc), 256'(4));
    chk("bp in_ready", 256'(in_ready), 256'(0));
    chk("bp out_valid", 256'(out_valid), 256'(1));
    for (int i = 1; i <= 4; i++) recv("bp drain", 128'(i), 1'b0);
    chk("bp empty", 256'(out_valid), 256'(0));
    chk("bp in_ready back", 256'(in_ready), 256'(1));
    send(128'd7, 1'b1, 20, ok);
    recv("bp close", 128'd7, 1'b1);

    // Reserved mode
    do_kld(2'b11, 256'd0, 128'd0);
    chk("rsv err", 256'(err), 256'(1));
    chk("rsv idle", 256'(busy), 256'(0));
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    chk("err cleared by rst", 256'(err), 256'(0));

    // kld during WAIT: flagged, key and result untouched
    do_kld(2'b00, 256'd107, 128'd0);
    send(128'd100, 1'b1, 20, ok);
    @(negedge clk); @(negedge clk);
    do_kld(2'b01, 256'd0, 128'd5);
    chk("wait kld err", 256'(err), 256'(1));
    chk("wait kld key", core_key, 256'd107);
    recv("wait kld result", 128'h0F, 1'b1);

    // Reset while the core is working
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    do_kld(2'b00, 256'd107, 128'd0);
    send(128'd100, 1'b1, 20, ok);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst wait out_valid", 256'(out_valid), 256'(0));
    chk("rst wait busy", 256'(busy), 256'(0));
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("late done out_valid", 256'(out_valid), 256'(0));
    chk("late done busy", 256'(busy), 256'(0));
    chk("late done err", 256'(err), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
